// File: rtl/button_pulse_conditioner_if.sv
// button_pulse_conditioner_if: raw button levels in, mutually exclusive press pulses out
// Signals: add1_raw..add4_raw, rst1_raw, rst2_raw (raw levels from the panel)
//          add1..add4, rst1, rst2 (one-cycle press pulses to the meter controller)
// Modports: master drives the raw levels and receives pulses; slave is the conditioner.
interface button_pulse_conditioner_if;
    logic add1_raw, add2_raw, add3_raw, add4_raw, rst1_raw, rst2_raw;
    logic add1, add2, add3, add4, rst1, rst2;
    modport master (
        output add1_raw, add2_raw, add3_raw, add4_raw, rst1_raw, rst2_raw,
        input  add1, add2, add3, add4, rst1, rst2
    );
    modport slave (
        input  add1_raw, add2_raw, add3_raw, add4_raw, rst1_raw, rst2_raw,
        output add1, add2, add3, add4, rst1, rst2
    );
endinterface

// File: rtl/button_pulse_conditioner.sv
// button_pulse_conditioner: synchronize, debounce and serialize six pushbuttons into one-cycle pulses
// Ports: clk  system clock
//        rst  synchronous active-high reset
//        bus  slave side: six raw levels in, six mutually exclusive registered press pulses out
// Internal bit order is priority order: [5]=rst1 [4]=rst2 [3]=add1 [2]=add2 [1]=add3 [0]=add4.
module button_pulse_conditioner #(
    parameter int DEBOUNCE_CYCLES = 2,
    parameter int CNT_W = 4
) (
    input logic clk,
    input logic rst,
    button_pulse_conditioner_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT_PRESS, PRESSED, WAIT_RELEASE} state_t;
    localparam logic [CNT_W-1:0] DC = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    logic [5:0] raw, s1_q, s2_q, armed_q, armed_d, pend_q, pend_d, out_q, out_d, acc;
    logic [1:0] vld_q, vld_d;
    logic [CNT_W-1:0] inc;
    state_t st_q [6];
    state_t st_d [6];
    logic [CNT_W-1:0] cnt_q [6];
    logic [CNT_W-1:0] cnt_d [6];
    assign raw = {bus.rst1_raw, bus.rst2_raw, bus.add1_raw, bus.add2_raw, bus.add3_raw, bus.add4_raw};
    assign {bus.rst1, bus.rst2, bus.add1, bus.add2, bus.add3, bus.add4} = out_q;
    // s2 holds reset zeros for the first two edges after reset, not real button
    // samples; vld marks when s2 reflects the panel so a button held through
    // reset is not mistaken for released and armed.
    assign vld_d = {vld_q[0], 1'b1};
    always_comb begin
        armed_d = armed_q | (~s2_q & {6{vld_q[1]}});
        acc = '0;
        inc = '0;
        for (int b = 0; b < 6; b++) begin
            st_d[b] = st_q[b];
            cnt_d[b] = cnt_q[b];
            inc = cnt_q[b] + ONE;
            case (st_q[b])
                IDLE: if (s2_q[b] && armed_q[b]) begin
                    st_d[b] = (DC == ONE) ? PRESSED : WAIT_PRESS;
                    cnt_d[b] = (DC == ONE) ? '0 : ONE;
                    acc[b] = (DC == ONE);
                end
                WAIT_PRESS: begin
                    st_d[b] = !s2_q[b] ? IDLE : (inc == DC) ? PRESSED : WAIT_PRESS;
                    cnt_d[b] = (!s2_q[b] || inc == DC) ? '0 : inc;
                    acc[b] = s2_q[b] && inc == DC;
                end
                PRESSED: if (!s2_q[b]) begin
                    st_d[b] = (DC == ONE) ? IDLE : WAIT_RELEASE;
                    cnt_d[b] = (DC == ONE) ? '0 : ONE;
                end
                WAIT_RELEASE: begin
                    st_d[b] = s2_q[b] ? PRESSED : (inc == DC) ? IDLE : WAIT_RELEASE;
                    cnt_d[b] = (s2_q[b] || inc == DC) ? '0 : inc;
                end
            endcase
        end
    end
    // Ascending scan so the highest-priority pending bit wins.
    always_comb begin
        out_d = '0;
        for (int i = 0; i < 6; i++)
            if (pend_q[i]) begin
                out_d = '0;
                out_d[i] = 1'b1;
            end
        pend_d = (pend_q & ~out_d) | acc;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
            armed_q <= '0;
            pend_q <= '0;
            out_q <= '0;
            vld_q <= '0;
            for (int b = 0; b < 6; b++) begin
                st_q[b] <= IDLE;
                cnt_q[b] <= '0;
            end
        end else begin
            s1_q <= raw;
            s2_q <= s1_q;
            armed_q <= armed_d;
            pend_q <= pend_d;
            out_q <= out_d;
            vld_q <= vld_d;
            for (int b = 0; b < 6; b++) begin
                st_q[b] <= st_d[b];
                cnt_q[b] <= cnt_d[b];
            end
        end
    end
endmodule

// File: tb/tb_button_pulse_conditioner.sv
// tb_button_pulse_conditioner: checks a default build and a one-sample debounce build against a run-length model
module tb_button_pulse_conditioner;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [5:0] raw = '0;
    wire logic [5:0] o0, o1;
    int n_cmp = 0;
    int n_err = 0;
    int dcfg [2] = '{2, 1};
    string nm [6] = '{"add4", "add3", "add2", "add1", "rst2", "rst1"};
    logic [5:0] lvl [2], armed [2], pend [2], expv [2];
    int run [2][6];
    int pulses [2][6];
    logic [5:0] d1, d2;
    int since;

    button_pulse_conditioner_if bus0 ();
    button_pulse_conditioner_if bus1 ();
    assign {bus0.rst1_raw, bus0.rst2_raw, bus0.add1_raw, bus0.add2_raw, bus0.add3_raw, bus0.add4_raw} = raw;
    assign {bus1.rst1_raw, bus1.rst2_raw, bus1.add1_raw, bus1.add2_raw, bus1.add3_raw, bus1.add4_raw} = raw;
    assign o0 = {bus0.rst1, bus0.rst2, bus0.add1, bus0.add2, bus0.add3, bus0.add4};
    assign o1 = {bus1.rst1, bus1.rst2, bus1.add1, bus1.add2, bus1.add3, bus1.add4};

    button_pulse_conditioner #(.DEBOUNCE_CYCLES(2), .CNT_W(4)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    button_pulse_conditioner #(.DEBOUNCE_CYCLES(1), .CNT_W(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    // Reference: the button is seen two samples late; its debounced level flips
    // after DEBOUNCE_CYCLES consecutive opposite samples (presses only once armed
    // by a genuine low sample); each rise joins a pending set drained one
    // highest-priority button per edge.
    task automatic model_edge();
        logic [5:0] s, np, nx;
        logic valid, found;
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                lvl[c] = '0; armed[c] = '0; pend[c] = '0; expv[c] = '0;
                for (int b = 0; b < 6; b++) run[c][b] = 0;
            end
            d1 = '0; d2 = '0; since = 0;
        end else begin
            s = d2;
            valid = since >= 2;
            for (int c = 0; c < 2; c++) begin
                np = '0; nx = '0; found = 1'b0;
                for (int b = 5; b >= 0; b--)
                    if (pend[c][b] && !found) begin nx[b] = 1'b1; found = 1'b1; end
                for (int b = 0; b < 6; b++) begin
                    if (!lvl[c][b]) begin
                        if (s[b] && armed[c][b]) begin
                            run[c][b]++;
                            if (run[c][b] == dcfg[c]) begin lvl[c][b] = 1'b1; run[c][b] = 0; np[b] = 1'b1; end
                        end else run[c][b] = 0;
                    end else begin
                        if (!s[b]) begin
                            run[c][b]++;
                            if (run[c][b] == dcfg[c]) begin lvl[c][b] = 1'b0; run[c][b] = 0; end
                        end else run[c][b] = 0;
                    end
                    if (valid && !s[b]) armed[c][b] = 1'b1;
                end
                expv[c] = nx;
                pend[c] = (pend[c] & ~nx) | np;
            end
            d2 = d1; d1 = raw; since++;
        end
    endtask

    task automatic tick();
        logic [5:0] o;
        @(posedge clk);
        #1;
        model_edge();
        for (int c = 0; c < 2; c++) begin
            o = c == 0 ? o0 : o1;
            n_cmp++;
            assert (o === expv[c]) else begin
                n_err++;
                $error("FAIL out_cfg%0d: observed %b expected %b", c, o, expv[c]);
            end
            n_cmp++;
            assert ($onehot0(o)) else begin
                n_err++;
                $error("FAIL onehot_cfg%0d: observed %b expected at most one bit set", c, o);
            end
            for (int b = 0; b < 6; b++) pulses[c][b] += int'(o[b]);
        end
    endtask

    task automatic clr();
        for (int c = 0; c < 2; c++)
            for (int b = 0; b < 6; b++) pulses[c][b] = 0;
    endtask

    task automatic check_count(input int c, input int b, input int want);
        n_cmp++;
        assert (pulses[c][b] === want) else begin
            n_err++;
            $error("FAIL count_cfg%0d_%s: observed %0d expected %0d", c, nm[b], pulses[c][b], want);
        end
    endtask

    task automatic expect_counts(input logic [5:0] ones);
        for (int b = 0; b < 6; b++) check_count(0, b, int'(ones[b]));
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        repeat (10) tick();
        // clean press of add1
        clr();
        raw[3] = 1'b1; repeat (20) tick();
        raw[3] = 1'b0; repeat (10) tick();
        expect_counts(6'b001000);
        // add2 bounces 1,0,1,0 then settles high
        clr();
        raw[2] = 1'b1; tick(); raw[2] = 1'b0; tick();
        raw[2] = 1'b1; tick(); raw[2] = 1'b0; tick();
        raw[2] = 1'b1; repeat (10) tick();
        raw[2] = 1'b0; repeat (10) tick();
        expect_counts(6'b000100);
        // rst1, add1, add3 together
        clr();
        raw = 6'b101010; repeat (8) tick();
        raw = '0; repeat (10) tick();
        expect_counts(6'b101010);
        // rst2 long hold with a glitch after release
        clr();
        raw[4] = 1'b1; repeat (50) tick();
        raw[4] = 1'b0; repeat (2) tick();
        raw[4] = 1'b1; tick();
        raw[4] = 1'b0; repeat (10) tick();
        expect_counts(6'b010000);
        // reset while add4 is being debounced, then release and re-press
        clr();
        raw[0] = 1'b1; repeat (3) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        repeat (5) tick();
        raw[0] = 1'b0; repeat (4) tick();
        raw[0] = 1'b1; repeat (10) tick();
        raw[0] = 1'b0; repeat (10) tick();
        expect_counts(6'b000001);
        // single-cycle add3 tap: accepted only by the one-sample build
        clr();
        raw[1] = 1'b1; tick();
        raw[1] = 1'b0; repeat (10) tick();
        check_count(1, 1, 1);
        check_count(0, 1, 0);
        // random bouncy buttons with occasional resets
        repeat (600) begin
            for (int b = 0; b < 6; b++)
                if ($urandom_range(7) == 0) raw[b] = ~raw[b];
            rst = $urandom_range(149) == 0;
            tick();
        end
        rst = 1'b0;
        raw = '0;
        repeat (20) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/button_pulse_conditioner.md
Name: button_pulse_conditioner

Overview:
- Front-end stage that sits directly upstream of the parking meter controller.
- Takes six raw, bouncy pushbutton levels (add1..add4, rst1, rst2) on the 100 Hz system clock.
- Synchronizes and debounces each level, then emits exactly one single-cycle pulse per physical press.
- Serializes simultaneous presses so at most one output pulse is high in any cycle, in the controller's priority order (rst1 > rst2 > add1 > add2 > add3 > add4).

Parameters:
DEBOUNCE_CYCLES, 2, consecutive stable synchronized samples needed to accept a press or a release; legal range 1..15.
CNT_W, 4, width of each per-button debounce counter; must hold DEBOUNCE_CYCLES.

Ports:
clk  input  1  system clock (100 Hz tick domain of the meter).
rst  input  1  synchronous, active-high reset.
add1_raw  input  1  raw button level, asynchronous.
add2_raw  input  1  raw button level, asynchronous.
add3_raw  input  1  raw button level, asynchronous.
add4_raw  input  1  raw button level, asynchronous.
rst1_raw  input  1  raw button level, asynchronous.
rst2_raw  input  1  raw button level, asynchronous.
add1, add2, add3, add4, rst1, rst2  output  1 each  registered one-cycle press pulses, mutually exclusive.

Behaviour:
- Reset and clocking:
  - One clock. Reset is synchronous and active-high.
  - On rst, all synchronizer flops, FSMs (to IDLE), counters, pending bits and all six outputs go to 0. Reset mid-press discards that press.
  - A button still held when rst deasserts must be released (debounced) and pressed again before it can pulse.
  - To enforce this, each FSM leaves reset in IDLE but requires a debounced low (s2 low) before it may accept a press: an internal armed flag, cleared by rst and set on the first s2-low sample.
- Synchronizer: per button, 2-flop chain raw→s1→s2. Only s2 is used downstream.
- Per-button FSM, evaluated on s2 each edge:
  - IDLE: s2=1 and armed → WAIT_PRESS, cnt=1.
  - WAIT_PRESS: s2=0 → IDLE, cnt=0. s2=1 → cnt+1. When cnt+1 reaches DEBOUNCE_CYCLES → PRESSED and set pending[b].
    - DEBOUNCE_CYCLES=1: IDLE goes directly to PRESSED on the first s2=1 sample.
  - PRESSED: s2=1 → stay; no auto-repeat. s2=0 → WAIT_RELEASE, cnt=1.
  - WAIT_RELEASE: s2=1 → PRESSED, no new pulse. s2=0 → cnt+1; reaching DEBOUNCE_CYCLES → IDLE.
- Pending and output stage:
  - pending is a 6-bit register. Each edge, outputs <= one-hot of the highest-priority bit of the current pending (rst1 highest, add4 lowest), or all 0 if pending is empty.
  - That bit is cleared while newly accepted presses are OR'd in the same edge.
  - A re-accepted press of a still-pending button merges (idempotent OR).
- Latency, uncontested press: raw high and stable before edge k gives s1 at k, s2 at k+1, FSM first sees it at k+2. pending sets at edge k+1+DEBOUNCE_CYCLES. The output is high for exactly one cycle after edge k+2+DEBOUNCE_CYCLES (k+4 at default).
- Contested presses: N buttons accepted on the same edge pulse on N consecutive cycles in priority order.
- Glitch rejection: a raw pulse shorter than DEBOUNCE_CYCLES synchronized samples produces no output. A bounce on release shorter than DEBOUNCE_CYCLES produces no second pulse.
- Invariant: at most one output high per cycle.

Test Plan:
- Clean press: add1_raw high from edge 10 for 20 cycles (DEBOUNCE_CYCLES=2) → add1=1 only in the cycle after edge 14; all other outputs 0 throughout.
- Bounce rejection: add2_raw toggles 1,0,1,0 on single cycles, then stays high → no pulse for the toggles; exactly one add2 pulse DEBOUNCE_CYCLES+2 edges after the final rise.
- Simultaneous: rst1_raw, add3_raw and add1_raw rise at the same edge k → rst1 after edge k+4, add1 after k+5, add3 after k+6; never two outputs high together.
- Long hold and release bounce: rst2_raw held 50 cycles, then released with a 1-cycle high glitch 2 cycles after release → exactly one rst2 pulse total.
- Reset mid-operation: add4_raw rises at k; rst asserted at edge k+3 for one cycle while add4_raw stays high → no add4 pulse. After release (≥2 low cycles) and a re-press, one add4 pulse at the normal latency.
- DEBOUNCE_CYCLES=1 build: add3_raw high 1 cycle → one add3 pulse 3 edges later.
